// File: rtl/alpaca_ospfb_constants_pkg.sv
// ---------------------------------------------------------------------------
// alpaca_ospfb_constants_pkg
// Purpose : Build-wide OSPFB constants shared by the filterbank stages.
//           FFT_LEN is the branch count M (frame length).
//           DEC_FAC is the decimation factor D, 1 <= D <= M.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package alpaca_ospfb_constants_pkg;

    localparam int FFT_LEN = 8;
    localparam int DEC_FAC = 6;

endpackage

// File: rtl/alpaca_ospfb_ix_pkg.sv
// ---------------------------------------------------------------------------
// alpaca_ospfb_ix_pkg
// Purpose : Index and phase helpers for the OSPFB phase-compensation and
//           reorder stages. Holds gcd(), the number of distinct circular
//           shift offsets (NUM_STATES), the phase-state type and the
//           ping-pong sequencer state type.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package alpaca_ospfb_ix_pkg;

    import alpaca_ospfb_constants_pkg::*;

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // The offset walks 0, D, 2D, ... mod M and comes back to 0 after
    // M/gcd(M,D) frames.
    function automatic int num_states(input int m, input int d);
        return m / gcd(m, d);
    endfunction

    // A single-state counter still needs a one-bit port.
    function automatic int state_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_STATES = num_states(FFT_LEN, DEC_FAC);
    localparam int PHASE_W    = state_width(NUM_STATES);

    typedef logic [PHASE_W-1:0] phasecomp_state_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } phasecomp_fsm_t;

endpackage

// File: rtl/phase_offset_ctr.sv
// ---------------------------------------------------------------------------
// phase_offset_ctr
// Purpose : Modulo-M accumulator stepped by D once per enable. Produces the
//           circular shift offset and the index of that offset within its
//           cycle of NS values. Shared with the PFB reorder stage.
// Ports   :
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   en            in   advance to the next offset
//   shift_offset  out  current offset, 0..M-1
//   phase_state   out  current offset index, 0..NS-1
// ---------------------------------------------------------------------------
module phase_offset_ctr
    import alpaca_ospfb_ix_pkg::*;
#(
    parameter int M   = alpaca_ospfb_constants_pkg::FFT_LEN,
    parameter int D   = alpaca_ospfb_constants_pkg::DEC_FAC,
    parameter int SW  = $clog2(M),
    parameter int NS  = NUM_STATES,
    parameter int PSW = PHASE_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [SW-1:0]  shift_offset,
    output logic [PSW-1:0] phase_state
);

    logic [SW-1:0]  r_offset;
    logic [PSW-1:0] r_phase;
    logic [SW:0]    w_sum;
    logic [SW-1:0]  w_offsetNext;

    // Both operands are below M (D may equal M), so one conditional
    // subtract is a complete modulo.
    assign w_sum = {1'b0, r_offset} + (SW+1)'(D);

    always_comb begin
        w_offsetNext = w_sum[SW-1:0];
        if (w_sum >= (SW+1)'(M)) begin
            w_offsetNext = SW'(w_sum - (SW+1)'(M));
        end
    end

    // With NS == 1 the wrap compare is always true, pinning phase at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset <= '0;
            r_phase  <= '0;
        end else if (en) begin
            r_offset <= w_offsetNext;
            if (r_phase == PSW'(NS - 1)) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PSW'(1);
            end
        end
    end

    assign shift_offset = r_offset;
    assign phase_state  = r_phase;

endmodule

// File: rtl/phasecomp_ctrl.sv
// ---------------------------------------------------------------------------
// phasecomp_ctrl
// Purpose : Sequencer for the OSPFB phase-compensation ping-pong RAM
//           (2*FFT_LEN deep). Each accepted upstream beat writes one sample
//           into the write bank and, once the first frame is in, reads one
//           sample from the other bank rotated by the current shift offset.
// Ports   :
//   clk, rst         clock, asynchronous active-high reset
//   s_axis_tvalid    in   upstream sample valid
//   s_axis_tready    out  upstream ready (combinational)
//   m_axis_tvalid    out  RAM read data valid (registered)
//   m_axis_tready    in   downstream ready
//   m_axis_tlast     out  last beat of an output frame (registered)
//   ram_we/waddr     out  RAM write strobe / address
//   ram_re/raddr     out  RAM read strobe / address (dout updates on ram_re)
//   shift_offset     out  offset applied to the frame being read
//   phase_state      out  index of the current offset
// ---------------------------------------------------------------------------
module phasecomp_ctrl
    import alpaca_ospfb_ix_pkg::*;
#(
    parameter  int FFT_LEN = alpaca_ospfb_constants_pkg::FFT_LEN,
    parameter  int DEC_FAC = alpaca_ospfb_constants_pkg::DEC_FAC,
    parameter  int AW      = $clog2(2 * FFT_LEN),
    parameter  int SW      = $clog2(FFT_LEN),
    localparam int NSTATES = num_states(FFT_LEN, DEC_FAC),
    localparam int PSW     = state_width(NSTATES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_axis_tvalid,
    output logic           s_axis_tready,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    output logic           m_axis_tlast,
    output logic           ram_we,
    output logic [AW-1:0]  ram_waddr,
    output logic           ram_re,
    output logic [AW-1:0]  ram_raddr,
    output logic [SW-1:0]  shift_offset,
    output logic [PSW-1:0] phase_state
);

    phasecomp_fsm_t r_state;
    phasecomp_fsm_t w_nextState;

    logic          r_wbank;
    logic [SW-1:0] r_widx;
    logic          r_mValid;
    logic          r_mLast;

    logic          w_sReady;
    logic          w_advance;
    logic          w_lastIdx;
    logic          w_frameEnd;
    logic          w_offsetEn;
    logic [SW-1:0] w_offset;
    logic [SW:0]   w_ridxSum;
    logic [SW-1:0] w_rdIdx;

    // FILL never stalls: nothing is being read, so there is no output to
    // back up.
    assign w_sReady   = (r_state == FILL) || !r_mValid || m_axis_tready;
    assign w_advance  = s_axis_tvalid && w_sReady;
    assign w_lastIdx  = (r_widx == SW'(FFT_LEN - 1));
    assign w_frameEnd = w_advance && w_lastIdx;
    assign w_offsetEn = w_frameEnd && (r_state == RUN);

    phase_offset_ctr #(
        .M   (FFT_LEN),
        .D   (DEC_FAC),
        .SW  (SW),
        .NS  (NSTATES),
        .PSW (PSW)
    ) u_phase_offset_ctr (
        .clk          (clk),
        .rst          (rst),
        .en           (w_offsetEn),
        .shift_offset (w_offset),
        .phase_state  (phase_state)
    );

    assign shift_offset = w_offset;

    // Read index equals write index; rotate it by the offset mod M.
    assign w_ridxSum = {1'b0, r_widx} + {1'b0, w_offset};

    always_comb begin
        w_rdIdx = w_ridxSum[SW-1:0];
        if (w_ridxSum >= (SW+1)'(FFT_LEN)) begin
            w_rdIdx = SW'(w_ridxSum - (SW+1)'(FFT_LEN));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if ((r_state == FILL) && w_frameEnd) begin
            w_nextState = RUN;
        end
    end

    // Reads always come from the bank opposite the write bank. The read
    // address is parked at 0 while filling so it matches the reset value.
    always_comb begin
        s_axis_tready = w_sReady;
        ram_we        = w_advance;
        ram_waddr     = r_wbank ? (AW'(FFT_LEN) + AW'(r_widx)) : AW'(r_widx);
        ram_re        = 1'b0;
        ram_raddr     = '0;
        if (r_state == RUN) begin
            ram_re    = w_advance;
            ram_raddr = r_wbank ? AW'(w_rdIdx) : (AW'(FFT_LEN) + AW'(w_rdIdx));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbank <= 1'b0;
            r_widx  <= '0;
        end else if (w_advance) begin
            if (w_lastIdx) begin
                r_widx  <= '0;
                r_wbank <= !r_wbank;
            end else begin
                r_widx  <= r_widx + SW'(1);
            end
        end
    end

    // Valid/last track the RAM dout register: set on a read, cleared once
    // the beat is taken without a new read behind it, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
        end else if (w_advance && (r_state == RUN)) begin
            r_mValid <= 1'b1;
            r_mLast  <= w_lastIdx;
        end else if (m_axis_tready) begin
            r_mValid <= 1'b0;
            r_mLast  <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_mValid;
    assign m_axis_tlast  = r_mLast;

endmodule

// File: tb/tb_phasecomp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phasecomp_ctrl
// Directed bench for phasecomp_ctrl. Instance A runs M=8, D=6; instance B
// runs M=8, D=8 on the same upstream/downstream stimulus.
// ---------------------------------------------------------------------------
module tb_phasecomp_ctrl;

    logic       clk;
    logic       rst;
    logic       sValid;
    logic       mReady;

    logic       sReadyA;
    logic       mValidA;
    logic       mLastA;
    logic       ramWeA;
    logic [3:0] ramWaddrA;
    logic       ramReA;
    logic [3:0] ramRaddrA;
    logic [2:0] offsetA;
    logic [1:0] phaseA;

    logic       sReadyB;
    logic       mValidB;
    logic       mLastB;
    logic       ramWeB;
    logic [3:0] ramWaddrB;
    logic       ramReB;
    logic [3:0] ramRaddrB;
    logic [2:0] offsetB;
    logic [0:0] phaseB;

    int checks;
    int errors;

    // Hand-computed offsets/phases per read frame for M=8, D=6.
    int offs [6] = '{0, 6, 4, 2, 0, 6};
    int phs  [6] = '{0, 1, 2, 3, 0, 1};

    phasecomp_ctrl #(
        .FFT_LEN (8),
        .DEC_FAC (6)
    ) dutA (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (sValid),
        .s_axis_tready (sReadyA),
        .m_axis_tvalid (mValidA),
        .m_axis_tready (mReady),
        .m_axis_tlast  (mLastA),
        .ram_we        (ramWeA),
        .ram_waddr     (ramWaddrA),
        .ram_re        (ramReA),
        .ram_raddr     (ramRaddrA),
        .shift_offset  (offsetA),
        .phase_state   (phaseA)
    );

    phasecomp_ctrl #(
        .FFT_LEN (8),
        .DEC_FAC (8)
    ) dutB (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (sValid),
        .s_axis_tready (sReadyB),
        .m_axis_tvalid (mValidB),
        .m_axis_tready (mReady),
        .m_axis_tlast  (mLastB),
        .ram_we        (ramWeB),
        .ram_waddr     (ramWaddrB),
        .ram_re        (ramReB),
        .ram_raddr     (ramRaddrB),
        .shift_offset  (offsetB),
        .phase_state   (phaseB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic ready);
        sValid = valid;
        mReady = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        checkOutput("rst_tvalid", mValidA, 0);
        checkOutput("rst_tlast", mLastA, 0);
        checkOutput("rst_we", ramWeA, 0);
        checkOutput("rst_re", ramReA, 0);
        checkOutput("rst_waddr", ramWaddrA, 0);
        checkOutput("rst_raddr", ramRaddrA, 0);
        checkOutput("rst_offset", offsetA, 0);
        checkOutput("rst_phase", phaseA, 0);
        checkOutput("rst_tready", sReadyA, 1);
        rst = 1'b0;

        // Six frames at full rate: frame 0 fills, frames 1..5 read back
        // frames 0..4 with offsets 0,6,4,2,0.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'b1, 1'b1);
                #1;
                checkOutput("run_tready", sReadyA, 1);
                checkOutput("run_we", ramWeA, 1);
                checkOutput("run_waddr", ramWaddrA, (f % 2) * 8 + i);
                checkOutput("run_re", ramReA, (f > 0) ? 1 : 0);
                checkOutput("run_raddr", ramRaddrA,
                            (f > 0) ? ((f - 1) % 2) * 8 + (i + offs[f-1]) % 8 : 0);
                checkOutput("run_offset", offsetA, (f > 0) ? offs[f-1] : 0);
                checkOutput("run_phase", phaseA, (f > 0) ? phs[f-1] : 0);
                checkOutput("dEqM_raddr", ramRaddrB, (f > 0) ? ((f - 1) % 2) * 8 + i : 0);
                checkOutput("dEqM_offset", offsetB, 0);
                checkOutput("dEqM_phase", phaseB, 0);
                @(posedge clk);
                #1;
                checkOutput("run_tvalid", mValidA, (f > 0) ? 1 : 0);
                checkOutput("run_tlast", mLastA, (f > 0 && i == 7) ? 1 : 0);
            end
        end

        // Frame 6 writes bank 0, reads frame 5 from bank 1 with offset 6.
        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("f6_raddr0", ramRaddrA, 14);
        @(posedge clk);
        #1;

        // Downstream stall: upstream must see not-ready, no RAM activity.
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("stall_tready", sReadyA, 0);
        checkOutput("stall_re", ramReA, 0);
        checkOutput("stall_we", ramWeA, 0);
        checkOutput("stall_raddr", ramRaddrA, 15);
        @(posedge clk);
        #1;
        checkOutput("stall_tvalid", mValidA, 1);
        checkOutput("stall_waddr", ramWaddrA, 1);

        applyStimulus(1'b1, 1'b1);
        #1;
        checkOutput("unstall_re", ramReA, 1);
        checkOutput("unstall_raddr", ramRaddrA, 15);
        @(posedge clk);
        #1;

        // Upstream gap: pending beat drains, counters freeze.
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("gap_we", ramWeA, 0);
        checkOutput("gap_re", ramReA, 0);
        checkOutput("gap_tready", sReadyA, 1);
        @(posedge clk);
        #1;
        checkOutput("gap_tvalid", mValidA, 0);
        @(posedge clk);
        #1;
        checkOutput("gap_waddr", ramWaddrA, 2);
        checkOutput("gap_offset", offsetA, 6);
        checkOutput("gap_phase", phaseA, 1);

        for (int i = 2; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1);
            #1;
            checkOutput("resume_waddr", ramWaddrA, i);
            checkOutput("resume_raddr", ramRaddrA, 8 + (i + 6) % 8);
            @(posedge clk);
            #1;
            checkOutput("resume_tvalid", mValidA, 1);
        end

        // Mid-frame reset at widx=5: cleared without any clock edge.
        applyStimulus(1'b0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_tvalid", mValidA, 0);
        checkOutput("arst_tlast", mLastA, 0);
        checkOutput("arst_waddr", ramWaddrA, 0);
        checkOutput("arst_raddr", ramRaddrA, 0);
        checkOutput("arst_re", ramReA, 0);
        checkOutput("arst_offset", offsetA, 0);
        checkOutput("arst_phase", phaseA, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Restart: bank 0 refills with no output for 8 beats.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1);
            #1;
            checkOutput("refill_waddr", ramWaddrA, (i < 8) ? i : 8);
            checkOutput("refill_re", ramReA, (i < 8) ? 0 : 1);
            checkOutput("refill_raddr", ramRaddrA, 0);
            @(posedge clk);
            #1;
            checkOutput("refill_tvalid", mValidA, (i < 8) ? 0 : 1);
        end

        applyStimulus(1'b0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
